// File: rtl/egress_if.sv
// Packet handshake bundle between the switch core, an egress buffer and its port consumer.
interface egress_if #(
    parameter int PACKET_WIDTH = 16
);
    logic                    in_valid;
    logic [PACKET_WIDTH-1:0] in_data;
    logic                    out_valid;
    logic [PACKET_WIDTH-1:0] out_data;
    logic                    out_ready;

    modport master (output in_valid, in_data, out_ready, input out_valid, out_data);
    modport slave  (input in_valid, in_data, out_ready, output out_valid, out_data);
endinterface

// File: rtl/egress_buffer.sv
// Per-port egress FIFO: accepts packets targeted at PORT_ID, presents them to the port consumer.
// Define EGRESS_STATS_EN to build the drop/misroute statistics counters.
module egress_buffer #(
    parameter int DEPTH        = 8,
    parameter int PACKET_WIDTH = 16,
    parameter int PORT_ID      = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    egress_if.slave                      bus,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         full,
    output logic                         empty,
    output logic [15:0]                  drop_cnt,
    output logic [15:0]                  misroute_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_t;

    state_t                  state_reg, state_next;
    logic [AW-1:0]           wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]           count_reg;
    logic [PACKET_WIDTH-1:0] mem [DEPTH];

    logic match, flushing, at_full, push, pop;

    assign match    = bus.in_data[4+PORT_ID];
    // The flush input takes effect on the very edge it is seen, before the state reaches FLUSH.
    assign flushing = flush || (state_reg == FLUSH);
    assign at_full  = (count_reg == CW'(DEPTH));
    assign push     = bus.in_valid && match && !flushing && !at_full;
    assign pop      = (state_reg == SEND) && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push)
                    wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH-1)) ? '0 : wr_ptr_reg + 1'b1;
                if (pop)
                    rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH-1)) ? '0 : rd_ptr_reg + 1'b1;
                count_reg <= count_reg + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= bus.in_data;
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = FLUSH;
        end else begin
            case (state_reg)
                IDLE:    if (push) state_next = SEND;
                SEND:    if (pop && !push && count_reg == CW'(1)) state_next = IDLE;
                FLUSH:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Head entry is presented in the same cycle it lands, giving one-cycle push-to-valid latency.
    assign bus.out_valid = (state_reg == SEND);
    assign bus.out_data  = bus.out_valid ? mem[rd_ptr_reg] : '0;
    assign fifo_count    = count_reg;
    assign full          = at_full;
    assign empty         = (count_reg == '0);

`ifdef EGRESS_STATS_EN
    logic        drop_ev, mis_ev;
    logic [15:0] drop_cnt_reg, mis_cnt_reg;

    assign drop_ev = bus.in_valid && match && (flushing || at_full);
    assign mis_ev  = bus.in_valid && !match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_reg <= '0;
            mis_cnt_reg  <= '0;
        end else begin
            if (drop_ev && drop_cnt_reg != 16'hFFFF)
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            if (mis_ev && mis_cnt_reg != 16'hFFFF)
                mis_cnt_reg <= mis_cnt_reg + 16'd1;
        end
    end

    assign drop_cnt     = drop_cnt_reg;
    assign misroute_cnt = mis_cnt_reg;
`else
    assign drop_cnt     = 16'd0;
    assign misroute_cnt = 16'd0;
`endif

endmodule
